rooth_timer: RTL and testbench

Memory-mapped machine timer that is the interrupt source for the core's interrupt controller. It counts clock ticks against a software-programmed compare value and raises a level interrupt flag on the `int_flag` bus, which the controller samples alongside `mstatus.MIE`. The flag stays asserted until the ISR clears it through the timer's register port. The timer is reached over the core's simple peripheral bus: select, write enable, address and data.

---
 rtl/rooth_timer_pkg.sv | 32 +++
 rtl/rooth_timer_if.sv | 35 +++
 rtl/rooth_timer_presc.sv | 34 +++
 rtl/rooth_timer.sv | 161 ++++++++++++++++
 tb/tb_rooth_timer.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rooth_timer_pkg.sv
// rooth_timer_pkg: shared constants for the machine timer and the interrupt bus.
// Holds the interrupt codes, the register byte offsets and the CTRL bit positions
// that sit alongside INT_BUS/INT_NONE in the core's shared definitions.
package rooth_timer_pkg;

    localparam int CPU_WIDTH = 32;
    localparam int INT_BUS   = 8;

    localparam logic [INT_BUS-1:0] INT_NONE   = 8'h00;
    localparam logic [INT_BUS-1:0] INT_TIMER0 = 8'h01;

    // Byte offsets of the timer registers inside its window
    localparam logic [3:0] TIMER_CTRL  = 4'h0;
    localparam logic [3:0] TIMER_COUNT = 4'h4;
    localparam logic [3:0] TIMER_VALUE = 4'h8;
    localparam logic [3:0] TIMER_PRESC = 4'hC;

    // CTRL bit positions
    localparam int TIMER_EN_BIT      = 0;
    localparam int TIMER_IE_BIT      = 1;
    localparam int TIMER_PEND_BIT    = 2;
    localparam int TIMER_ONESHOT_BIT = 3;

    // Word index decoded from addr[3:2]
    typedef enum logic [1:0] {
        REG_CTRL  = 2'd0,
        REG_COUNT = 2'd1,
        REG_VALUE = 2'd2,
        REG_PRESC = 2'd3
    } timer_reg_e;

endpackage

// File: rtl/rooth_timer_if.sv
// rooth_timer_if: the core's simple peripheral bus as seen by the timer,
// plus the interrupt flag the timer drives towards the interrupt controller.
interface rooth_timer_if #(
    parameter int TIMER_AW = 4
);
    import rooth_timer_pkg::*;

    logic                 sel_i;
    logic                 we_i;
    logic [TIMER_AW-1:0]  addr_i;
    logic [CPU_WIDTH-1:0] wdata_i;
    logic [CPU_WIDTH-1:0] rdata_o;
    logic [INT_BUS-1:0]   int_flag_o;

    // Core / bus side
    modport master (
        output sel_i,
        output we_i,
        output addr_i,
        output wdata_i,
        input  rdata_o,
        input  int_flag_o
    );

    // Timer side
    modport slave (
        input  sel_i,
        input  we_i,
        input  addr_i,
        input  wdata_i,
        output rdata_o,
        output int_flag_o
    );

endinterface

// File: rtl/rooth_timer_presc.sv
// rooth_timer_presc: prescaler tick generator. Emits one tick every i_presc+1
// clocks while i_en is high; the first tick comes a full interval after i_en
// rises. Dropping i_en or pulsing i_restart returns the divider to 0.
module rooth_timer_presc #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic [PRESC_W-1:0] i_presc,
    input  logic               i_restart,
    output logic               o_tick
);

    logic [PRESC_W-1:0] r_cnt;
    logic               w_wrap;

    assign w_wrap = (r_cnt == i_presc);
    assign o_tick = i_en & w_wrap;

    // Divider counter: held at 0 while disabled or restarted, wraps at i_presc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || i_restart) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rooth_timer.sv
// rooth_timer: memory-mapped machine timer, interrupt source INT_TIMER0.
// Registers: CTRL (EN/IE/PEND/ONESHOT), COUNT, VALUE (period), PRESC.
// Optional feature macro: ROOTH_TIMER_PRESCALER_EN -- when defined, PRESC is a
// real PRESC_W-bit divider; otherwise PRESC reads 0 and the timer ticks every clk.
module rooth_timer
    import rooth_timer_pkg::*;
#(
    parameter int TIMER_AW = 4,
    parameter int PRESC_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rooth_timer_if.slave  bus
);

    logic                 r_en;
    logic                 r_ie;
    logic                 r_pend;
    logic                 r_oneshot;
    logic [CPU_WIDTH-1:0] r_count;
    logic [CPU_WIDTH-1:0] r_value;
    logic [CPU_WIDTH-1:0] r_rdata;

    logic                 w_wr;
    logic                 w_rd;
    timer_reg_e           w_reg;
    logic                 w_wr_ctrl;
    logic                 w_wr_count;
    logic                 w_wr_value;
    logic                 w_tick;
    logic                 w_step;
    logic [CPU_WIDTH-1:0] w_count_inc;
    logic                 w_match;
    logic [PRESC_W-1:0]   w_presc_val;
    logic [CPU_WIDTH-1:0] w_presc_rd;
    logic [CPU_WIDTH-1:0] w_ctrl_rd;
    logic                 w_addr_unused;

    // Only addr[3:2] selects a register; the remaining offset bits are don't-care
    assign w_addr_unused = ^bus.addr_i;

    assign w_wr       = bus.sel_i &  bus.we_i;
    assign w_rd       = bus.sel_i & ~bus.we_i;
    assign w_reg      = timer_reg_e'(bus.addr_i[3:2]);
    assign w_wr_ctrl  = w_wr && (w_reg == REG_CTRL);
    assign w_wr_count = w_wr && (w_reg == REG_COUNT);
    assign w_wr_value = w_wr && (w_reg == REG_VALUE);

`ifdef ROOTH_TIMER_PRESCALER_EN
    logic               r_presc;
    logic [PRESC_W-1:0] r_presc_val;
    logic               w_wr_presc;

    assign w_wr_presc  = w_wr && (w_reg == REG_PRESC);
    assign w_presc_val = r_presc_val;

    // PRESC register; a write also restarts the divider inside the prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc_val <= '0;
        end else if (w_wr_presc) begin
            r_presc_val <= bus.wdata_i[PRESC_W-1:0];
        end
    end

    rooth_timer_presc #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (r_en),
        .i_presc   (r_presc_val),
        .i_restart (w_wr_presc),
        .o_tick    (r_presc)
    );

    assign w_tick = r_presc;
`else
    // Without the prescaler every enabled clock is a tick and PRESC reads 0
    assign w_presc_val = '0;
    assign w_tick      = r_en;
`endif

    assign w_presc_rd = {{(CPU_WIDTH-PRESC_W){1'b0}}, w_presc_val};

    // A software COUNT write suppresses both the increment and the compare
    assign w_step      = w_tick & r_en & ~w_wr_count;
    assign w_count_inc = r_count + 1'b1;
    assign w_match     = w_step && (r_value != '0) && (w_count_inc == r_value);

    // CTRL readback assembled from the individual flag registers
    always_comb begin
        w_ctrl_rd                    = '0;
        w_ctrl_rd[TIMER_EN_BIT]      = r_en;
        w_ctrl_rd[TIMER_IE_BIT]      = r_ie;
        w_ctrl_rd[TIMER_PEND_BIT]    = r_pend;
        w_ctrl_rd[TIMER_ONESHOT_BIT] = r_oneshot;
    end

    // CTRL flags: software write wins for EN; a match set wins over a PEND clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en      <= 1'b0;
            r_ie      <= 1'b0;
            r_pend    <= 1'b0;
            r_oneshot <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en      <= bus.wdata_i[TIMER_EN_BIT];
                r_ie      <= bus.wdata_i[TIMER_IE_BIT];
                r_oneshot <= bus.wdata_i[TIMER_ONESHOT_BIT];
            end else if (w_match && r_oneshot) begin
                r_en <= 1'b0;
            end
            if (w_match) begin
                r_pend <= 1'b1;
            end else if (w_wr_ctrl && bus.wdata_i[TIMER_PEND_BIT]) begin
                r_pend <= 1'b0;
            end
        end
    end

    // COUNT: software write, else increment on tick, reload to 0 on match
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= bus.wdata_i;
        end else if (w_step) begin
            r_count <= w_match ? '0 : w_count_inc;
        end
    end

    // VALUE: plain software register holding the period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (w_wr_value) begin
            r_value <= bus.wdata_i;
        end
    end

    // Registered read port; holds its last value when not reading
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            unique case (w_reg)
                REG_CTRL:  r_rdata <= w_ctrl_rd;
                REG_COUNT: r_rdata <= r_count;
                REG_VALUE: r_rdata <= r_value;
                REG_PRESC: r_rdata <= w_presc_rd;
                default:   r_rdata <= '0;
            endcase
        end
    end

    assign bus.rdata_o    = r_rdata;
    assign bus.int_flag_o = (r_pend & r_ie) ? INT_TIMER0 : INT_NONE;

endmodule

// File: tb/tb_rooth_timer.sv
// tb_rooth_timer: self-checking bench for rooth_timer. Read expectations are
// queued when a read is issued and compared when rdata_o returns; interrupt
// flag checks are made inline by each scenario task.
module tb_rooth_timer;
    import rooth_timer_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic rd_seen;

    logic [31:0] exp_q[$];
    string       nm_q[$];

    rooth_timer_if #(.TIMER_AW(4)) bus ();

    rooth_timer #(.TIMER_AW(4), .PRESC_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: a read accepted at a rising edge is compared at the next falling edge
    always @(posedge clk) rd_seen <= bus.sel_i & ~bus.we_i & rst_n;

    always @(negedge clk) begin
        if (rd_seen) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow rdata=%h expected=none", bus.rdata_o);
            end else begin
                logic [31:0] e;
                string       n;
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                if (bus.rdata_o !== e) begin
                    errors++;
                    $display("FAIL %s rdata=%h expected=%h", n, bus.rdata_o, e);
                end
            end
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.sel_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.addr_i  = a;
        bus.wdata_i = d;
        @(negedge clk);
        bus.sel_i   = 1'b0;
        bus.we_i    = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] e, input string n);
        bus.sel_i  = 1'b1;
        bus.we_i   = 1'b0;
        bus.addr_i = a;
        exp_q.push_back(e);
        nm_q.push_back(n);
        @(negedge clk);
        bus.sel_i  = 1'b0;
    endtask

    task automatic stop_timer();
        bus_write(TIMER_CTRL, 32'h0);
        bus_write(TIMER_CTRL, 32'h4);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.int_flag_o !== INT_NONE) begin
            errors++;
            $display("FAIL reset_flag flag=%h expected=%h", bus.int_flag_o, INT_NONE);
        end
        checks++;
        if (bus.rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata rdata=%h expected=0", bus.rdata_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(TIMER_CTRL,  32'h0, "reset_ctrl");
        bus_read(TIMER_COUNT, 32'h0, "reset_count");
        bus_read(TIMER_VALUE, 32'h0, "reset_value");
        bus_read(TIMER_PRESC, 32'h0, "reset_presc");
    endtask

    task automatic test_basic_period();
        stop_timer();
        bus_write(TIMER_VALUE, 32'd5);
        bus_write(TIMER_COUNT, 32'd0);
        bus_write(TIMER_CTRL,  32'h3);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.int_flag_o !== INT_NONE) begin
                errors++;
                $display("FAIL basic_flag_early k=%0d flag=%h expected=%h", k, bus.int_flag_o, INT_NONE);
            end
            bus_read(TIMER_COUNT, 32'(k), "basic_count");
        end
        checks++;
        if (bus.int_flag_o !== INT_TIMER0) begin
            errors++;
            $display("FAIL basic_flag_match flag=%h expected=%h", bus.int_flag_o, INT_TIMER0);
        end
        bus_read(TIMER_COUNT, 32'h0, "basic_count_reload");
        bus_read(TIMER_CTRL,  32'h7, "basic_ctrl_pend");
    endtask

    task automatic test_clear_freerun();
        bus_write(TIMER_CTRL, 32'h7);
        checks++;
        if (bus.int_flag_o !== INT_NONE) begin
            errors++;
            $display("FAIL clear_flag flag=%h expected=%h", bus.int_flag_o, INT_NONE);
        end
        bus_read(TIMER_CTRL, 32'h3, "clear_ctrl");
        checks++;
        if (bus.int_flag_o !== INT_NONE) begin
            errors++;
            $display("FAIL clear_flag_before_next flag=%h expected=%h", bus.int_flag_o, INT_NONE);
        end
        @(negedge clk);
        checks++;
        if (bus.int_flag_o !== INT_TIMER0) begin
            errors++;
            $display("FAIL clear_next_period flag=%h expected=%h", bus.int_flag_o, INT_TIMER0);
        end
    endtask

    task automatic test_oneshot();
        stop_timer();
        bus_write(TIMER_VALUE, 32'd3);
        bus_write(TIMER_COUNT, 32'd0);
        bus_write(TIMER_CTRL,  32'h9);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.int_flag_o !== INT_NONE) begin
            errors++;
            $display("FAIL oneshot_flag_ie_off flag=%h expected=%h", bus.int_flag_o, INT_NONE);
        end
        bus_read(TIMER_CTRL,  32'hC, "oneshot_ctrl");
        bus_read(TIMER_COUNT, 32'h0, "oneshot_count");
        bus_read(TIMER_COUNT, 32'h0, "oneshot_count_held");
    endtask

    task automatic test_collisions();
        // PEND clear-write landing on the match edge
        stop_timer();
        bus_write(TIMER_VALUE, 32'd4);
        bus_write(TIMER_COUNT, 32'd0);
        bus_write(TIMER_CTRL,  32'h3);
        repeat (3) @(negedge clk);
        bus_write(TIMER_CTRL,  32'h7);
        checks++;
        if (bus.int_flag_o !== INT_TIMER0) begin
            errors++;
            $display("FAIL coll_pend_flag flag=%h expected=%h", bus.int_flag_o, INT_TIMER0);
        end
        bus_read(TIMER_CTRL, 32'h7, "coll_pend_ctrl");
        // COUNT write during a tick: no increment that cycle
        bus_write(TIMER_COUNT, 32'h10);
        bus_read(TIMER_COUNT, 32'h10, "coll_count_write");
        bus_read(TIMER_COUNT, 32'h11, "coll_count_next");
        // CTRL.EN write on a one-shot match edge
        stop_timer();
        bus_write(TIMER_VALUE, 32'd2);
        bus_write(TIMER_COUNT, 32'd0);
        bus_write(TIMER_CTRL,  32'hB);
        @(negedge clk);
        bus_write(TIMER_CTRL,  32'h9);
        checks++;
        if (bus.int_flag_o !== INT_NONE) begin
            errors++;
            $display("FAIL coll_en_flag flag=%h expected=%h", bus.int_flag_o, INT_NONE);
        end
        bus_read(TIMER_CTRL,  32'hD, "coll_en_ctrl");
        bus_read(TIMER_COUNT, 32'h1, "coll_en_count");
    endtask

    task automatic test_value0_wrap();
        stop_timer();
        bus_write(TIMER_VALUE, 32'h0);
        bus_write(TIMER_COUNT, 32'hFFFF_FFFE);
        bus_write(TIMER_CTRL,  32'h3);
        bus_read(TIMER_COUNT, 32'hFFFF_FFFE, "wrap_count0");
        bus_read(TIMER_COUNT, 32'hFFFF_FFFF, "wrap_count1");
        bus_read(TIMER_COUNT, 32'h0000_0000, "wrap_count2");
        bus_read(TIMER_COUNT, 32'h0000_0001, "wrap_count3");
        bus_read(TIMER_CTRL,  32'h3,         "wrap_no_pend");
        checks++;
        if (bus.int_flag_o !== INT_NONE) begin
            errors++;
            $display("FAIL wrap_flag flag=%h expected=%h", bus.int_flag_o, INT_NONE);
        end
    endtask

    task automatic test_prescaler();
        stop_timer();
`ifdef ROOTH_TIMER_PRESCALER_EN
        bus_write(TIMER_COUNT, 32'd0);
        bus_write(TIMER_VALUE, 32'd2);
        bus_write(TIMER_PRESC, 32'd2);
        bus_write(TIMER_CTRL,  32'h3);
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (bus.int_flag_o !== INT_NONE) begin
                errors++;
                $display("FAIL presc_flag_early clk=%0d flag=%h expected=%h", k, bus.int_flag_o, INT_NONE);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.int_flag_o !== INT_TIMER0) begin
            errors++;
            $display("FAIL presc_flag_6clk flag=%h expected=%h", bus.int_flag_o, INT_TIMER0);
        end
        bus_read(TIMER_PRESC, 32'd2, "presc_read");
        stop_timer();
        bus_write(TIMER_PRESC, 32'd0);
`else
        bus_write(TIMER_PRESC, 32'hFF);
        bus_read(TIMER_PRESC, 32'h0, "presc_absent");
`endif
    endtask

    task automatic test_back_to_back();
        stop_timer();
        bus_write(TIMER_VALUE, 32'h1234);
        bus_write(TIMER_COUNT, 32'hABCD);
        bus_read(TIMER_CTRL,  32'h0,    "b2b_ctrl");
        bus_read(TIMER_COUNT, 32'hABCD, "b2b_count");
        bus_read(TIMER_VALUE, 32'h1234, "b2b_value");
        repeat (2) @(negedge clk);
        checks++;
        if (bus.rdata_o !== 32'h1234) begin
            errors++;
            $display("FAIL b2b_rdata_hold rdata=%h expected=%h", bus.rdata_o, 32'h1234);
        end
        bus_read(TIMER_COUNT, 32'hABCD, "b2b_count_idle");
    endtask

    task automatic test_async_reset();
        stop_timer();
        bus_write(TIMER_VALUE, 32'd2);
        bus_write(TIMER_COUNT, 32'd0);
        bus_write(TIMER_CTRL,  32'h3);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.int_flag_o !== INT_TIMER0) begin
            errors++;
            $display("FAIL areset_pre_flag flag=%h expected=%h", bus.int_flag_o, INT_TIMER0);
        end
        bus_read(TIMER_VALUE, 32'd2, "areset_pre_value");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.int_flag_o !== INT_NONE) begin
            errors++;
            $display("FAIL areset_flag flag=%h expected=%h", bus.int_flag_o, INT_NONE);
        end
        checks++;
        if (bus.rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL areset_rdata rdata=%h expected=0", bus.rdata_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(TIMER_CTRL,  32'h0, "areset_ctrl");
        bus_read(TIMER_COUNT, 32'h0, "areset_count");
        bus_read(TIMER_VALUE, 32'h0, "areset_value");
        bus_read(TIMER_COUNT, 32'h0, "areset_count_idle");
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.sel_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        @(negedge clk);
        test_reset();
        test_basic_period();
        test_clear_freerun();
        test_oneshot();
        test_collisions();
        test_value0_wrap();
        test_prescaler();
        test_back_to_back();
        test_async_reset();
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
